// File: rtl/cdb_arbiter_if.sv
// Bundle between the four functional units, the CDB arbiter and the CDB consumers.
// master = FU/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned N_FU   = 4
) ();

  logic [N_FU-1:0]        fu_valid;
  logic [N_FU*ROB_W-1:0]  fu_rob_entry;
  logic [N_FU*DATA_W-1:0] fu_result;
  logic [N_FU-1:0]        fu_ready;

  logic                   cdb_valid;
  logic [ROB_W-1:0]       cdb_rob_entry;
  logic [DATA_W-1:0]      cdb_value;
  logic [N_FU-1:0]        cdb_src;

  modport master (
    output fu_valid,
    output fu_rob_entry,
    output fu_result,
    input  fu_ready,
    input  cdb_valid,
    input  cdb_rob_entry,
    input  cdb_value,
    input  cdb_src
  );

  modport slave (
    input  fu_valid,
    input  fu_rob_entry,
    input  fu_result,
    output fu_ready,
    output cdb_valid,
    output cdb_rob_entry,
    output cdb_value,
    output cdb_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter with one result slot per functional unit.
// Define CDB_OUTREG_EN to register the cdb_* broadcast outputs (one extra cycle of latency).
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned N_FU   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]   slot_valid;
  logic [ROB_W-1:0]  slot_tag  [N_FU];
  logic [DATA_W-1:0] slot_data [N_FU];
  logic [PTR_W-1:0]  rr_ptr;

  logic [N_FU-1:0]   grant;
  logic              any_grant;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  scan_idx;
  logic [N_FU-1:0]   capture;

  logic              cdb_valid_c;
  logic [ROB_W-1:0]  cdb_rob_entry_c;
  logic [DATA_W-1:0] cdb_value_c;
  logic [N_FU-1:0]   cdb_src_c;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned   offs);
    return PTR_W'((32'(base) + offs) % N_FU);
  endfunction

  // Rotating-priority scan starting at rr_ptr; first occupied slot wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_FU; k++) begin
      scan_idx = wrap_add(rr_ptr, k);
      if (!any_grant && slot_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        winner          = scan_idx;
        any_grant       = 1'b1;
      end
    end
  end

  // A granted slot drains this cycle, so it may be refilled at the same edge.
  assign bus.fu_ready = ~slot_valid | grant;
  assign capture      = bus.fu_valid & bus.fu_ready & {N_FU{~flush}};

  always_comb begin
    cdb_valid_c     = any_grant & ~flush;
    cdb_rob_entry_c = '0;
    cdb_value_c     = '0;
    cdb_src_c       = '0;
    if (cdb_valid_c) begin
      cdb_rob_entry_c = slot_tag[winner];
      cdb_value_c     = slot_data[winner];
      cdb_src_c       = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      slot_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < N_FU; i++) begin
        if (capture[i]) begin
          slot_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (cdb_valid_c) begin
        rr_ptr <= wrap_add(winner, 1);
      end
    end
  end

  // Payload needs no reset: it is only observed while its slot_valid bit is set.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_FU; i++) begin
      if (capture[i]) begin
        slot_tag[i]  <= bus.fu_rob_entry[i*ROB_W +: ROB_W];
        slot_data[i] <= bus.fu_result[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CDB_OUTREG_EN
  logic              cdb_valid_q;
  logic [ROB_W-1:0]  cdb_rob_entry_q;
  logic [DATA_W-1:0] cdb_value_q;
  logic [N_FU-1:0]   cdb_src_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cdb_valid_q     <= 1'b0;
      cdb_rob_entry_q <= '0;
      cdb_value_q     <= '0;
      cdb_src_q       <= '0;
    end else begin
      cdb_valid_q     <= cdb_valid_c;
      cdb_rob_entry_q <= cdb_rob_entry_c;
      cdb_value_q     <= cdb_value_c;
      cdb_src_q       <= cdb_src_c;
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_entry = cdb_rob_entry_q;
  assign bus.cdb_value     = cdb_value_q;
  assign bus.cdb_src       = cdb_src_q;
`else
  assign bus.cdb_valid     = cdb_valid_c;
  assign bus.cdb_rob_entry = cdb_rob_entry_c;
  assign bus.cdb_value     = cdb_value_c;
  assign bus.cdb_src       = cdb_src_c;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a pending-result model checked every cycle, plus literal
// expectations read from a per-cycle log of DUT outputs.
module tb_cdb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 4;
  localparam int unsigned N_FU   = 4;
  localparam int          NF     = 4;
  localparam int          LOG_N  = 256;
`ifdef CDB_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;

  cdb_arbiter_if #(.DATA_W(DATA_W), .ROB_W(ROB_W), .N_FU(N_FU)) bus ();

  cdb_arbiter #(.DATA_W(DATA_W), .ROB_W(ROB_W), .N_FU(N_FU)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Stimulus payload per FU
  logic [3:0]  tg [NF];
  logic [31:0] dt [NF];

  task automatic step(input logic [3:0] v, input logic fl, input logic rs);
    bus.fu_valid = v;
    flush        = fl;
    reset        = rs;
    for (int i = 0; i < NF; i++) begin
      bus.fu_rob_entry[i*ROB_W +: ROB_W] = tg[i];
      bus.fu_result[i*DATA_W +: DATA_W]  = dt[i];
    end
    @(posedge clk);
    #1;
  endtask

  // Model: which FUs hold a pending result, and which FU has top priority next.
  bit          m_pend [NF];
  logic [3:0]  m_tag  [NF];
  logic [31:0] m_dat  [NF];
  int          m_ptr;
  logic        q_v;
  logic [3:0]  q_tag, q_src;
  logic [31:0] q_val;
  bit          armed = 1'b0;

  // Log of DUT outputs per cycle
  logic        lg_v   [LOG_N];
  logic [3:0]  lg_tag [LOG_N];
  logic [3:0]  lg_src [LOG_N];
  logic [3:0]  lg_rdy [LOG_N];
  logic [31:0] lg_val [LOG_N];
  int          lg_ptr [LOG_N];
  int          cyc = 0;

  always @(negedge clk) begin
    int          w, best, d;
    logic        ev, sv;
    logic [3:0]  etag, esrc, erdy, stag, ssrc;
    logic [31:0] eval, sval;

    // Winner: pending FU at the smallest circular distance from the priority pointer.
    w    = -1;
    best = NF;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i]) begin
        d = (i - m_ptr + NF) % NF;
        if (d < best) begin
          best = d;
          w    = i;
        end
      end
    end
    for (int i = 0; i < NF; i++) erdy[i] = !m_pend[i] || (i == w);
    ev   = (w >= 0) && !flush;
    etag = ev ? m_tag[w] : 4'h0;
    eval = ev ? m_dat[w] : 32'h0;
    esrc = ev ? (4'b0001 << w) : 4'b0000;

    if (LAT == 1) begin
      sv = q_v; stag = q_tag; sval = q_val; ssrc = q_src;
    end else begin
      sv = ev; stag = etag; sval = eval; ssrc = esrc;
    end

    if (armed) begin
      check("model_fu_ready", 64'(bus.fu_ready), 64'(erdy));
      check("model_cdb_valid", 64'(bus.cdb_valid), 64'(sv));
      check("model_cdb_rob_entry", 64'(bus.cdb_rob_entry), 64'(stag));
      check("model_cdb_value", 64'(bus.cdb_value), 64'(sval));
      check("model_cdb_src", 64'(bus.cdb_src), 64'(ssrc));
    end

    if (cyc < LOG_N) begin
      lg_v[cyc]   = bus.cdb_valid;
      lg_tag[cyc] = bus.cdb_rob_entry;
      lg_val[cyc] = bus.cdb_value;
      lg_src[cyc] = bus.cdb_src;
      lg_rdy[cyc] = bus.fu_ready;
      lg_ptr[cyc] = int'(dut.rr_ptr);
    end

    if (reset) begin
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
      m_ptr = 0;
      q_v = 1'b0; q_tag = '0; q_val = '0; q_src = '0;
      armed = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
      q_v = 1'b0; q_tag = '0; q_val = '0; q_src = '0;
    end else begin
      if (ev) begin
        m_pend[w] = 1'b0;
        m_ptr     = (w + 1) % NF;
      end
      for (int i = 0; i < NF; i++) begin
        if (bus.fu_valid[i] && erdy[i]) begin
          m_pend[i] = 1'b1;
          m_tag[i]  = bus.fu_rob_entry[i*ROB_W +: ROB_W];
          m_dat[i]  = bus.fu_result[i*DATA_W +: DATA_W];
        end
      end
      q_v = ev; q_tag = etag; q_val = eval; q_src = esrc;
    end
    cyc++;
  end

  int r0, t0, t1, t2, t3, t4, t5;
  logic [3:0] v;

  initial begin
    for (int i = 0; i < NF; i++) begin
      tg[i] = '0;
      dt[i] = '0;
    end
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);

    r0 = cyc;
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // All four FUs complete together, priority pointer at 0
    t0 = cyc;
    for (int i = 0; i < NF; i++) begin
      tg[i] = 4'(i + 1);
      dt[i] = 32'h1000 + 32'(i);
    end
    step(4'b1111, 1'b0, 1'b0);
    repeat (5) step(4'b0000, 1'b0, 1'b0);

    // Single result from FU2
    t1 = cyc;
    tg[2] = 4'h7;
    dt[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // FU0 and FU3 keep their slots full whenever they are ready
    t2 = cyc;
    for (int k = 0; k < 12; k++) begin
      v     = {bus.fu_ready[3], 2'b00, bus.fu_ready[0]};
      tg[0] = 4'(k);
      dt[0] = 32'hA000 + 32'(k);
      tg[3] = 4'(k + 8);
      dt[3] = 32'hB000 + 32'(k);
      step(v, 1'b0, 1'b0);
    end
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // FU1 refills its slot in the cycle that slot is granted
    t3 = cyc;
    tg[1] = 4'h5;
    dt[1] = 32'h55;
    step(4'b0010, 1'b0, 1'b0);
    tg[1] = 4'h9;
    dt[1] = 32'h99;
    step(4'b0010, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Flush with slots 0 and 2 occupied and FU1 completing in the flush cycle
    t4 = cyc;
    tg[0] = 4'hA;
    dt[0] = 32'hAAAA;
    tg[2] = 4'hB;
    dt[2] = 32'hBBBB;
    step(4'b0101, 1'b0, 1'b0);
    tg[1] = 4'hC;
    dt[1] = 32'hCCCC;
    step(4'b0010, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Reset two cycles into all-FU contention
    t5 = cyc;
    for (int i = 0; i < NF; i++) tg[i] = 4'(i + 1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Literal expectations from the log
    check("reset_fu_ready", 64'(lg_rdy[r0]), 64'h0F);
    check("reset_cdb_valid", 64'(lg_v[r0]), 64'h0);
    check("reset_cdb_rob_entry", 64'(lg_tag[r0]), 64'h0);
    check("reset_cdb_value", 64'(lg_val[r0]), 64'h0);
    check("reset_cdb_src", 64'(lg_src[r0]), 64'h0);
    check("reset_rr_ptr", 64'(lg_ptr[r0]), 64'h0);

    for (int k = 1; k <= 4; k++) begin
      check("contend_valid", 64'(lg_v[t0+k+LAT]), 64'h1);
      check("contend_tag", 64'(lg_tag[t0+k+LAT]), 64'(k));
      check("contend_src", 64'(lg_src[t0+k+LAT]), 64'(4'b0001 << (k - 1)));
      check("contend_fu_ready", 64'(lg_rdy[t0+k]), 64'((1 << k) - 1));
    end
    check("contend_drained", 64'(lg_v[t0+5+LAT]), 64'h0);

    check("single_valid", 64'(lg_v[t1+1+LAT]), 64'h1);
    check("single_tag", 64'(lg_tag[t1+1+LAT]), 64'h7);
    check("single_value", 64'(lg_val[t1+1+LAT]), 64'hDEADBEEF);
    check("single_src", 64'(lg_src[t1+1+LAT]), 64'h4);
    check("single_after", 64'(lg_v[t1+2+LAT]), 64'h0);
    check("single_rr_ptr", 64'(lg_ptr[t1+2]), 64'h3);

    for (int k = 1; k < 12; k++) begin
      check("fair_valid", 64'(lg_v[t2+k+LAT]), 64'h1);
      check("fair_src", 64'(lg_src[t2+k+LAT]), ((k % 2) == 1) ? 64'h8 : 64'h1);
    end

    check("refill_fu_ready", 64'(lg_rdy[t3+1]), 64'h0F);
    check("refill_first_tag", 64'(lg_tag[t3+1+LAT]), 64'h5);
    check("refill_second_valid", 64'(lg_v[t3+2+LAT]), 64'h1);
    check("refill_second_tag", 64'(lg_tag[t3+2+LAT]), 64'h9);
    check("refill_second_value", 64'(lg_val[t3+2+LAT]), 64'h99);
    check("refill_second_src", 64'(lg_src[t3+2+LAT]), 64'h2);
    check("refill_drained", 64'(lg_v[t3+3+LAT]), 64'h0);

    check("flush_cycle_valid", 64'(lg_v[t4+1]), 64'h0);
    check("flush_cycle_fu_ready", 64'(lg_rdy[t4+1]), 64'hE);
    check("flush_next_valid", 64'(lg_v[t4+2]), 64'h0);
    check("flush_next_fu_ready", 64'(lg_rdy[t4+2]), 64'h0F);
    check("flush_fu1_dropped", 64'(lg_v[t4+3]), 64'h0);

    check("midreset_valid", 64'(lg_v[t5+3]), 64'h0);
    check("midreset_fu_ready", 64'(lg_rdy[t5+3]), 64'h0F);
    check("midreset_rr_ptr", 64'(lg_ptr[t5+3]), 64'h0);
    check("midreset_empty", 64'(lg_v[t5+4]), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
